// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Initiator-side controller for an 8-bit combinational ALU.
//                Queues {A, B, Sel} commands in a small FIFO and issues them
//                one at a time on registered ALU drive lines. Each ALU result
//                is captured and returned on a valid/ready response port
//                with carry, divide-by-zero and select echo.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  // command port
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [7:0]       i_cmd_a,
  input  logic [7:0]       i_cmd_b,
  input  logic [3:0]       i_cmd_sel,
  // ALU drive / return
  output logic [7:0]       o_alu_a,
  output logic [7:0]       o_alu_b,
  output logic [3:0]       o_alu_sel,
  input  logic [7:0]       i_alu_out,
  input  logic             i_alu_carry,
  // response port
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [7:0]       o_rsp_data,
  output logic             o_rsp_carry,
  output logic             o_rsp_dz,
  output logic [3:0]       o_rsp_sel,
  // status
  output logic [CNT_W-1:0] o_cmd_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0] c_SEL_ADD = 4'b0000;
  localparam logic [3:0] c_SEL_DIV = 4'b0011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // FIFO entry layout: {sel, b, a}
  logic [19:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  state_t           r_state;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic [3:0]       r_alu_sel;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_data;
  logic             r_rsp_carry;
  logic             r_rsp_dz;
  logic [3:0]       r_rsp_sel;

  logic             w_not_full;
  logic             w_not_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_rsp_hs;
  logic             w_dz;
  logic [19:0]      w_head;

  // Ready is derived from registered occupancy only, so a full FIFO never
  // accepts a push even when a pop happens in the same cycle.
  assign w_not_full  = (r_count < CNT_W'(DEPTH));
  assign w_not_empty = (r_count != '0);
  assign w_push      = i_cmd_valid && w_not_full;
  assign w_rsp_hs    = r_rsp_valid && i_rsp_ready;
  // A new command is pulled either from IDLE or straight out of a completed
  // response handshake, which gives back-to-back 2-cycle issue.
  assign w_pop       = w_not_empty &&
                       ((r_state == S_IDLE) || ((r_state == S_RESP) && w_rsp_hs));
  assign w_head      = r_mem[r_rd_ptr];
  // Divide by zero is decided from the issued operands; ALU output is ignored.
  assign w_dz        = (r_alu_sel == c_SEL_DIV) && (r_alu_b == 8'h00);

  // FIFO storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_cmd_sel, i_cmd_b, i_cmd_a};
    end
  end

  // FIFO pointers (wrap naturally modulo DEPTH) and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Issue/capture FSM with registered ALU drive and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_dz    <= 1'b0;
      r_rsp_sel   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_alu_sel, r_alu_b, r_alu_a} <= w_head;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data  <= w_dz ? 8'hFF : i_alu_out;
          r_rsp_carry <= i_alu_carry && (r_alu_sel == c_SEL_ADD);
          r_rsp_dz    <= w_dz;
          r_rsp_sel   <= r_alu_sel;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            if (w_pop) begin
              {r_alu_sel, r_alu_b, r_alu_a} <= w_head;
              r_state <= S_EXEC;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = w_not_full;
  assign o_cmd_count = r_count;
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_sel   = r_alu_sel;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_carry = r_rsp_carry;
  assign o_rsp_dz    = r_rsp_dz;
  assign o_rsp_sel   = r_rsp_sel;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Scoreboard testbench for alu_cmd_sequencer with a behavioural
//                8-bit ALU attached to the drive lines.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_cmd_valid = 1'b0;
  logic             o_cmd_ready;
  logic [7:0]       i_cmd_a = '0;
  logic [7:0]       i_cmd_b = '0;
  logic [3:0]       i_cmd_sel = '0;
  logic [7:0]       o_alu_a;
  logic [7:0]       o_alu_b;
  logic [3:0]       o_alu_sel;
  logic [7:0]       i_alu_out;
  logic             i_alu_carry;
  logic             o_rsp_valid;
  logic             i_rsp_ready = 1'b1;
  logic [7:0]       o_rsp_data;
  logic             o_rsp_carry;
  logic             o_rsp_dz;
  logic [3:0]       o_rsp_sel;
  logic [CNT_W-1:0] o_cmd_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // expected response packed as {sel, dz, carry, data}
  logic [13:0] exp_q[$];

  alu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_a     (i_cmd_a),
    .i_cmd_b     (i_cmd_b),
    .i_cmd_sel   (i_cmd_sel),
    .o_alu_a     (o_alu_a),
    .o_alu_b     (o_alu_b),
    .o_alu_sel   (o_alu_sel),
    .i_alu_out   (i_alu_out),
    .i_alu_carry (i_alu_carry),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_carry (o_rsp_carry),
    .o_rsp_dz    (o_rsp_dz),
    .o_rsp_sel   (o_rsp_sel),
    .o_cmd_count (o_cmd_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: returns {carry_of_add, result}. Carry is driven for every
  // op so the sequencer has to mask it; divide by zero returns a junk value.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] s);
    logic [8:0] sum;
    logic [7:0] r;
    sum = {1'b0, a} + {1'b0, b};
    case (s)
      4'd0:    r = sum[7:0];
      4'd1:    r = a - b;
      4'd2:    r = a * b;
      4'd3:    r = (b == 8'h00) ? 8'h5A : (a / b);
      4'd4:    r = a << 1;
      4'd5:    r = a >> 1;
      4'd6:    r = {a[6:0], a[7]};
      4'd7:    r = {a[0], a[7:1]};
      4'd8:    r = a & b;
      4'd9:    r = a | b;
      4'd10:   r = a ^ b;
      4'd11:   r = ~(a | b);
      4'd12:   r = ~(a & b);
      4'd13:   r = ~(a ^ b);
      4'd14:   r = (a > b) ? 8'd1 : 8'd0;
      default: r = (a == b) ? 8'd1 : 8'd0;
    endcase
    return {sum[8], r};
  endfunction

  always_comb {i_alu_carry, i_alu_out} = alu_fn(o_alu_a, o_alu_b, o_alu_sel);

  // Reference response for a command.
  function automatic logic [13:0] ref_rsp(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s);
    logic [8:0] f;
    f = alu_fn(a, b, s);
    if (s == 4'd3 && b == 8'h00) return {4'd3, 1'b1, 1'b0, 8'hFF};
    return {s, 1'b0, (s == 4'd0) && f[8], f[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle a response is valid it must match the queue head;
  // it is retired on the handshake. This also checks hold stability.
  always @(negedge clk) begin
    if (rst_n && o_rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got 0x%0h, expected no response (cycle %0d)",
                 {o_rsp_sel, o_rsp_dz, o_rsp_carry, o_rsp_data}, cyc);
      end else begin
        chk("rsp", {18'd0, o_rsp_sel, o_rsp_dz, o_rsp_carry, o_rsp_data}, {18'd0, exp_q[0]});
        if (i_rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Offer one command for up to max_wait+1 cycles; expected result is queued
  // only when the DUT is seen ready, i.e. when it will be accepted.
  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                          input logic [13:0] exp, input int max_wait, output bit ok);
    ok = 1'b0;
    i_cmd_valid = 1'b1;
    i_cmd_a = a;
    i_cmd_b = b;
    i_cmd_sel = s;
    for (int w = 0; w <= max_wait; w++) begin
      @(negedge clk);
      if (o_cmd_ready) begin
        exp_q.push_back(exp);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !o_rsp_valid) break;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_idle", {31'd0, o_rsp_valid}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    int n0;
    logic [7:0] ra, rb;
    logic [3:0] rs;

    // ---- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", {29'd0, o_cmd_count}, 0);
    chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 0);
    chk("rst_alu", {12'd0, o_alu_sel, o_alu_b, o_alu_a}, 0);
    chk("rst_rsp", {18'd0, o_rsp_sel, o_rsp_dz, o_rsp_carry, o_rsp_data}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, o_cmd_ready}, 1);
    @(posedge clk);
    #1;

    // ---- 1: add, latency (issued after edge N, valid after edge N+3)
    n0 = cyc;
    send_cmd(8'h0B, 8'h0A, 4'b0000, {4'd0, 1'b0, 1'b0, 8'h15}, 3, ok);
    chk("t1_accept", {31'd0, ok}, 1);
    chk("t1_accept_edge", cyc, n0 + 1);
    @(negedge clk);
    @(negedge clk);
    chk("t1_lat_early", {31'd0, o_rsp_valid}, 0);
    @(negedge clk);
    chk("t1_lat_valid", {31'd0, o_rsp_valid}, 1);
    wait_drain(20);

    // ---- 2: add carry, sub with carry masked
    send_cmd(8'hFF, 8'h01, 4'b0000, {4'd0, 1'b0, 1'b1, 8'h00}, 3, ok);
    chk("t2_accept_a", {31'd0, ok}, 1);
    send_cmd(8'hFF, 8'h01, 4'b0001, {4'd1, 1'b0, 1'b0, 8'hFE}, 3, ok);
    chk("t2_accept_b", {31'd0, ok}, 1);
    wait_drain(20);

    // ---- 3: divide by zero and normal divide
    send_cmd(8'h10, 8'h00, 4'b0011, {4'd3, 1'b1, 1'b0, 8'hFF}, 3, ok);
    chk("t3_accept_a", {31'd0, ok}, 1);
    send_cmd(8'h10, 8'h04, 4'b0011, {4'd3, 1'b0, 1'b0, 8'h04}, 3, ok);
    chk("t3_accept_b", {31'd0, ok}, 1);
    wait_drain(20);

    // ---- 4: stall, fill to capacity, then drain in order
    i_rsp_ready = 1'b0;
    acc = 0;
    send_cmd(8'h81, 8'h03, 4'd0, {4'd0, 1'b0, 1'b0, 8'h84}, 2, ok); acc += int'(ok);
    send_cmd(8'h81, 8'h03, 4'd1, {4'd1, 1'b0, 1'b0, 8'h7E}, 2, ok); acc += int'(ok);
    send_cmd(8'h81, 8'h03, 4'd2, {4'd2, 1'b0, 1'b0, 8'h83}, 2, ok); acc += int'(ok);
    send_cmd(8'h81, 8'h03, 4'd3, {4'd3, 1'b0, 1'b0, 8'h2B}, 2, ok); acc += int'(ok);
    send_cmd(8'h81, 8'h03, 4'd4, {4'd4, 1'b0, 1'b0, 8'h02}, 2, ok); acc += int'(ok);
    send_cmd(8'h81, 8'h03, 4'd5, {4'd5, 1'b0, 1'b0, 8'h40}, 2, ok); acc += int'(ok);
    chk("t4_accepted", acc, 5);
    chk("t4_sixth_rejected", {31'd0, ok}, 0);
    @(negedge clk);
    chk("t4_ready_low", {31'd0, o_cmd_ready}, 0);
    chk("t4_count_full", {29'd0, o_cmd_count}, 4);
    repeat (4) @(posedge clk);
    #1 i_rsp_ready = 1'b1;
    wait_drain(40);

    // ---- 5: reset while a command is in EXEC
    send_cmd(8'h01, 8'h02, 4'd0, {4'd0, 1'b0, 1'b0, 8'h03}, 3, ok);
    send_cmd(8'h22, 8'h11, 4'd1, {4'd1, 1'b0, 1'b0, 8'h11}, 3, ok);
    send_cmd(8'h0F, 8'hF0, 4'd8, {4'd8, 1'b0, 1'b0, 8'h00}, 3, ok);
    @(posedge clk);
    #1;
    chk("t5_count_pre", {29'd0, o_cmd_count}, 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t5_count_rst", {29'd0, o_cmd_count}, 0);
    chk("t5_valid_rst", {31'd0, o_rsp_valid}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_count_after", {29'd0, o_cmd_count}, 0);
    chk("t5_valid_after", {31'd0, o_rsp_valid}, 0);
    send_cmd(8'h33, 8'h44, 4'd0, {4'd0, 1'b0, 1'b0, 8'h77}, 3, ok);
    chk("t5_fresh_accept", {31'd0, ok}, 1);
    wait_drain(20);

    // ---- 6: fill and drain three times with random commands
    for (int rep = 0; rep < 3; rep++) begin
      i_rsp_ready = 1'b0;
      acc = 0;
      for (int k = 0; k < 8; k++) begin
        ra = 8'($urandom);
        rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        rs = 4'($urandom_range(0, 15));
        send_cmd(ra, rb, rs, ref_rsp(ra, rb, rs), 2, ok);
        if (!ok) break;
        acc++;
      end
      chk("t6_fill", acc, 5);
      chk("t6_count_full", {29'd0, o_cmd_count}, 4);
      repeat (2) @(posedge clk);
      #1 i_rsp_ready = 1'b1;
      wait_drain(60);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
